// File: rtl/slot_table_port_arbiter_if.sv
// Port-A bus of the submit slot table arbiter: two requester channels plus
// the RAM port-A side. The arbiter takes the slave view; requesters and the
// RAM side (a single bench or wrapper) take the master view.
interface slot_table_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16
);
    // requester 0: network-management configuration path
    logic                  i_req0;
    logic                  i_wr0;
    logic [ADDR_WIDTH-1:0] iv_addr0;
    logic [DATA_WIDTH-1:0] iv_wdata0;
    logic                  o_ack0;
    logic [DATA_WIDTH-1:0] ov_rdata0;
    logic                  o_rdata_valid0;

    // requester 1: local debug/readback path
    logic                  i_req1;
    logic                  i_wr1;
    logic [ADDR_WIDTH-1:0] iv_addr1;
    logic [DATA_WIDTH-1:0] iv_wdata1;
    logic                  o_ack1;
    logic [DATA_WIDTH-1:0] ov_rdata1;
    logic                  o_rdata_valid1;

    // slot table RAM port A
    logic [ADDR_WIDTH-1:0] ov_ram_addr;
    logic [DATA_WIDTH-1:0] ov_ram_wdata;
    logic                  o_ram_wr;
    logic                  o_ram_rd;
    logic [DATA_WIDTH-1:0] iv_ram_rdata;

    logic                  o_busy;

    modport slave (
        input  i_req0, i_wr0, iv_addr0, iv_wdata0,
        output o_ack0, ov_rdata0, o_rdata_valid0,
        input  i_req1, i_wr1, iv_addr1, iv_wdata1,
        output o_ack1, ov_rdata1, o_rdata_valid1,
        output ov_ram_addr, ov_ram_wdata, o_ram_wr, o_ram_rd,
        input  iv_ram_rdata,
        output o_busy
    );

    modport master (
        output i_req0, i_wr0, iv_addr0, iv_wdata0,
        input  o_ack0, ov_rdata0, o_rdata_valid0,
        output i_req1, i_wr1, iv_addr1, iv_wdata1,
        input  o_ack1, ov_rdata1, o_rdata_valid1,
        input  ov_ram_addr, ov_ram_wdata, o_ram_wr, o_ram_rd,
        output iv_ram_rdata,
        input  o_busy
    );
endinterface

// File: rtl/slot_table_port_arbiter.sv
// Round-robin arbiter for port A of the 1024x16 submit slot table RAM.
// Requester 0 (configuration) and requester 1 (debug readback) share the
// port; one access is in flight at a time. Writes hold wren for a single
// cycle, reads hold rden for RD_LATENCY+1 cycles and capture q_a on the
// last one. Every access ends with a one-cycle DONE state carrying the
// ack (and read-valid) pulse, which gives the requester time to drop its
// request before the arbiter looks again.
module slot_table_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    slot_table_port_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE_S  = 2'd0;
    localparam logic [1:0] WRITE_S = 2'd1;
    localparam logic [1:0] READ_S  = 2'd2;
    localparam logic [1:0] DONE_S  = 2'd3;

    // The read counter runs 0..RD_LATENCY while rden is held.
    localparam int CNT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY);

    logic [1:0]            state;
    logic [CNT_W-1:0]      rd_cnt;
    logic                  last_grant;
    logic                  win_id;

    logic                  ack0;
    logic                  ack1;
    logic                  rdata_valid0;
    logic                  rdata_valid1;
    logic [DATA_WIDTH-1:0] rdata0;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_wr;
    logic                  ram_rd;
    logic                  busy;

    logic                  any_req;
    logic                  pick;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Winner selection: a lone requester wins outright; on a tie the
    // requester that was not granted last time goes first.
    always_comb begin
        any_req   = bus.i_req0 | bus.i_req1;
        pick      = 1'b0;
        if (bus.i_req0 && bus.i_req1) begin
            pick = ~last_grant;
        end else if (bus.i_req1) begin
            pick = 1'b1;
        end
        sel_wr    = pick ? bus.i_wr1     : bus.i_wr0;
        sel_addr  = pick ? bus.iv_addr1  : bus.iv_addr0;
        sel_wdata = pick ? bus.iv_wdata1 : bus.iv_wdata0;
    end

    // Access sequencer: grant in IDLE, drive the RAM in WRITE/READ, pulse
    // the winner's ack in DONE, then release the address bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE_S;
            rd_cnt       <= '0;
            last_grant   <= 1'b1;
            win_id       <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata_valid0 <= 1'b0;
            rdata_valid1 <= 1'b0;
            rdata0       <= '0;
            rdata1       <= '0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_wr       <= 1'b0;
            ram_rd       <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE_S: begin
                    ram_wr <= 1'b0;
                    ram_rd <= 1'b0;
                    if (any_req) begin
                        win_id     <= pick;
                        last_grant <= pick;
                        ram_addr   <= sel_addr;
                        busy       <= 1'b1;
                        if (sel_wr) begin
                            ram_wdata <= sel_wdata;
                            ram_wr    <= 1'b1;
                            state     <= WRITE_S;
                        end else begin
                            ram_wdata <= '0;
                            ram_rd    <= 1'b1;
                            rd_cnt    <= '0;
                            state     <= READ_S;
                        end
                    end
                end

                WRITE_S: begin
                    ram_wr <= 1'b0;
                    if (win_id) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                    state <= DONE_S;
                end

                READ_S: begin
                    if (rd_cnt == CNT_LAST) begin
                        ram_rd <= 1'b0;
                        if (win_id) begin
                            rdata1       <= bus.iv_ram_rdata;
                            rdata_valid1 <= 1'b1;
                            ack1         <= 1'b1;
                        end else begin
                            rdata0       <= bus.iv_ram_rdata;
                            rdata_valid0 <= 1'b1;
                            ack0         <= 1'b1;
                        end
                        state <= DONE_S;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end

                default: begin
                    ack0         <= 1'b0;
                    ack1         <= 1'b0;
                    rdata_valid0 <= 1'b0;
                    rdata_valid1 <= 1'b0;
                    ram_addr     <= '0;
                    ram_wdata    <= '0;
                    busy         <= 1'b0;
                    state        <= IDLE_S;
                end
            endcase
        end
    end

    assign bus.o_ack0         = ack0;
    assign bus.o_ack1         = ack1;
    assign bus.o_rdata_valid0 = rdata_valid0;
    assign bus.o_rdata_valid1 = rdata_valid1;
    assign bus.ov_rdata0      = rdata0;
    assign bus.ov_rdata1      = rdata1;
    assign bus.ov_ram_addr    = ram_addr;
    assign bus.ov_ram_wdata   = ram_wdata;
    assign bus.o_ram_wr       = ram_wr;
    assign bus.o_ram_rd       = ram_rd;
    assign bus.o_busy         = busy;

endmodule

// File: doc/slot_table_port_arbiter.md
Name: slot_table_port_arbiter

Overview:
- Arbitrates port A of the 1024x16 submit slot table RAM between two requesters: requester 0 is the network-management configuration path, requester 1 is the local debug/readback path.
- Serialises accesses so only one requester drives the RAM at a time. Round-robin arbitration, full handshake.
- For reads, sequences the RAM's held-rden read with fixed latency and returns data to the winning requester.
- Sits between the configuration register interface and the submit schedule block's slot-table port A. Port B (the scheduler side) is untouched.

Parameters:
- ADDR_WIDTH, 10, RAM address width.
- DATA_WIDTH, 16, RAM data width.
- RD_LATENCY, 2, cycles from first rden-high sample to valid q_a.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req0  in  1  requester 0 access request, level, held until ack
- i_wr0  in  1  requester 0 op: 1=write, 0=read
- iv_addr0  in  ADDR_WIDTH  requester 0 address
- iv_wdata0  in  DATA_WIDTH  requester 0 write data
- o_ack0  out  1  requester 0 completion pulse
- ov_rdata0  out  DATA_WIDTH  requester 0 read data
- o_rdata_valid0  out  1  requester 0 read-data-valid pulse
- i_req1, i_wr1, iv_addr1, iv_wdata1, o_ack1, ov_rdata1, o_rdata_valid1: same roles for requester 1
- ov_ram_addr  out  ADDR_WIDTH  to RAM address_a
- ov_ram_wdata  out  DATA_WIDTH  to RAM data_a
- o_ram_wr  out  1  to RAM wren_a
- o_ram_rd  out  1  to RAM rden_a
- iv_ram_rdata  in  DATA_WIDTH  from RAM q_a
- o_busy  out  1  high whenever the FSM is not in IDLE_S

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs are 0.
  - FSM goes to IDLE_S; the rd counter clears.
  - The round-robin pointer is set to last_grant=1, so requester 0 wins the first tie.
  - An access in flight is dropped with no ack; requesters re-issue after reset.
- All outputs are registered.
- FSM states: IDLE_S, WRITE_S, READ_S, DONE_S.
- IDLE_S:
  - At each edge, if any request is high, select the winner. A single requester wins outright. If both are high, the winner is the one not equal to last_grant.
  - On selection, latch winner id, op, addr and wdata; update last_grant.
  - Write: set o_ram_wr=1, ov_ram_addr and ov_ram_wdata, go to WRITE_S.
  - Read: set o_ram_rd=1 and ov_ram_addr, clear the counter, go to READ_S.
  - No request: stay in IDLE_S with RAM controls at 0.
- WRITE_S (exactly 1 cycle with o_ram_wr=1):
  - At the edge, o_ram_wr<=0 and the winner's o_ack<=1.
  - Go to DONE_S.
- READ_S:
  - o_ram_rd stays high for exactly RD_LATENCY+1 consecutive cycles; the address is held stable throughout.
  - At the edge ending the last such cycle:
    - o_ram_rd<=0
    - winner's ov_rdata<=iv_ram_rdata
    - winner's o_rdata_valid<=1 and o_ack<=1
    - go to DONE_S
- DONE_S (1 cycle):
  - ack/valid are high this cycle and clear at the next edge.
  - Go to IDLE_S and clear o_ram_addr/o_ram_wdata to 0.
  - No new grant is made at this edge.
- Latency, from the IDLE_S grant edge:
  - Write: ack is high in the 2nd cycle after the grant.
  - Read: ack and valid are high in cycle RD_LATENCY+2 after the grant (4 cycles at default).
- Requester rule:
  - Keep req, op, addr and wdata stable from assertion until ack is sampled.
  - Deassert req at the edge where ack is sampled. IDLE_S then sees req=0 and no duplicate access occurs.
  - Back-to-back requests are allowed from the following cycle.
- ov_rdataN holds its value until the next read completes for that requester. Writes do not change it.
- Arbitration and fairness:
  - The non-winning request stays pending and is granted in the next IDLE_S cycle.
  - With both requesters continuously active, grants alternate strictly 0,1,0,1.
- o_ram_wr and o_ram_rd are never high together. ov_ram_addr changes only in IDLE_S or DONE_S.
- Inputs of a non-selected requester are ignored while the FSM is busy.

Test Plan:
- Single write, req0: addr=0x005, wdata=0x80A3, wr=1 -> o_ram_wr high for exactly 1 cycle with addr 0x005 and data 0x80A3; o_ack0 pulses 2 cycles after the grant; o_ack1 stays 0.
- Single read, req1: addr=0x005, RAM model returns 0x80A3 with 2-cycle latency -> o_ram_rd high for 3 cycles; ov_rdata1=0x80A3 with o_rdata_valid1 and o_ack1 high 4 cycles after the grant.
- Simultaneous req0 (write 0x010) and req1 (read 0x010) after reset -> req0 is served first, then req1 is read; read data equals the written value; o_ram_wr and o_ram_rd never overlap.
- Both requesters held active for 6 transactions -> grant order is 0,1,0,1,0,1; o_busy drops for exactly 1 cycle between accesses.
- i_rst_n pulsed low during READ_S -> all outputs are 0 immediately; no ack is issued; after release, req0 wins a simultaneous request.
- Requester drops req at ack, then re-asserts 1 cycle later -> exactly one RAM access per request, with no duplicate write.
